// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
// decode_if
// ----------------------------------------------------------------------------
// Bundle of the decode stage's fetch handshake, register-file read port,
// writeback bypass port, downstream handshake and registered decode outputs.
// Revision: 1.0
// ============================================================================
interface decode_if #(
  parameter int WIDTH = 16
) ();

  // Fetch side
  logic             invalid;
  logic [15:0]      instr;
  logic [WIDTH-1:0] pcin;
  logic             instready;

  // Register-file read port (same-cycle data)
  logic [2:0]       rs1addr;
  logic [2:0]       rs2addr;
  logic [WIDTH-1:0] rs1data;
  logic [WIDTH-1:0] rs2data;

  // Writeback port of the current cycle
  logic             wbenable;
  logic [2:0]       wbaddr;
  logic [WIDTH-1:0] wbdata;

  // Control and downstream handshake
  logic             flush;
  logic             outready;
  logic             outvalid;

  // Registered decode outputs
  logic [WIDTH-1:0] alu1;
  logic [WIDTH-1:0] alu2;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] storedata;
  logic [WIDTH-1:0] pcout;
  logic [3:0]       opcode;
  logic             writereg;
  logic [1:0]       memwrite;
  logic [2:0]       regaddress;

  // Environment side: drives instructions, register data and downstream ready
  modport master (
    output invalid, instr, pcin, rs1data, rs2data,
    output wbenable, wbaddr, wbdata, flush, outready,
    input  instready, rs1addr, rs2addr, outvalid,
    input  alu1, alu2, address, storedata, pcout,
    input  opcode, writereg, memwrite, regaddress
  );

  // Decode stage side
  modport slave (
    input  invalid, instr, pcin, rs1data, rs2data,
    input  wbenable, wbaddr, wbdata, flush, outready,
    output instready, rs1addr, rs2addr, outvalid,
    output alu1, alu2, address, storedata, pcout,
    output opcode, writereg, memwrite, regaddress
  );

endinterface : decode_if
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage
// ----------------------------------------------------------------------------
// Single-issue decode stage for a 16-bit instruction set with four classes
// (load, store, absolute load, ALU). Reads two register-file sources with an
// optional writeback bypass, detects load-use hazards against the held
// instruction, and presents the decoded fields in an output register guarded
// by a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module decode_stage #(
  parameter int WIDTH = 16,
  parameter int FWD   = 1
) (
  input  logic      clock,
  input  logic      resetn,
  decode_if.slave   bus
);

  // Instruction classes held in instr[15:14]
  localparam logic [1:0] c_CLS_LOAD  = 2'd0;
  localparam logic [1:0] c_CLS_STORE = 2'd1;
  localparam logic [1:0] c_CLS_ABS   = 2'd2;
  localparam logic [1:0] c_CLS_ALU   = 2'd3;

  // Memory access encoding for memwrite
  localparam logic [1:0] c_MEM_NONE  = 2'b00;
  localparam logic [1:0] c_MEM_LOAD  = 2'b01;
  localparam logic [1:0] c_MEM_STORE = 2'b10;

  // Largest ALU op that still takes its second operand from register B
  localparam logic [3:0] c_OP_LAST_REG = 4'd8;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [1:0]       w_cls;
  logic [2:0]       w_a;
  logic [2:0]       w_b;
  logic [3:0]       w_op;
  logic [7:0]       w_d;
  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_imm4;

  assign w_cls  = bus.instr[15:14];
  assign w_a    = bus.instr[13:11];
  assign w_b    = bus.instr[10:8];
  assign w_op   = bus.instr[7:4];
  assign w_d    = bus.instr[7:0];
  assign w_sext = {{(WIDTH-8){w_d[7]}}, w_d};
  assign w_imm4 = {{(WIDTH-4){1'b0}}, bus.instr[3:0]};

  // Register-file addresses are pure field extracts, independent of class
  assign bus.rs1addr = w_a;
  assign bus.rs2addr = w_b;

  // --------------------------------------------------------------------------
  // Source usage: which register operands the incoming instruction reads
  // --------------------------------------------------------------------------
  logic w_use1;
  logic w_use2;

  assign w_use1 = (w_cls == c_CLS_ALU) || (w_cls == c_CLS_STORE);
  assign w_use2 = (w_cls == c_CLS_LOAD) || (w_cls == c_CLS_STORE) ||
                  ((w_cls == c_CLS_ALU) && (w_op <= c_OP_LAST_REG));

  // --------------------------------------------------------------------------
  // Writeback bypass select
  // --------------------------------------------------------------------------
  logic w_fwd1;
  logic w_fwd2;

  generate
    if (FWD != 0) begin : g_fwd
      assign w_fwd1 = bus.wbenable && (bus.wbaddr == w_a);
      assign w_fwd2 = bus.wbenable && (bus.wbaddr == w_b);
    end else begin : g_no_fwd
      assign w_fwd1 = 1'b0;
      assign w_fwd2 = 1'b0;
    end
  endgenerate

  // Unused sources are forced to zero so every unused output field reads 0
  logic [WIDTH-1:0] w_src1;
  logic [WIDTH-1:0] w_src2;

  assign w_src1 = !w_use1 ? '0 : (w_fwd1 ? bus.wbdata : bus.rs1data);
  assign w_src2 = !w_use2 ? '0 : (w_fwd2 ? bus.wbdata : bus.rs2data);

  // --------------------------------------------------------------------------
  // Output register state
  // --------------------------------------------------------------------------
  logic             outvalid_q;
  logic [WIDTH-1:0] alu1_q,      alu1_d;
  logic [WIDTH-1:0] alu2_q,      alu2_d;
  logic [WIDTH-1:0] address_q,   address_d;
  logic [WIDTH-1:0] storedata_q, storedata_d;
  logic [WIDTH-1:0] pcout_q,     pcout_d;
  logic [3:0]       opcode_q,    opcode_d;
  logic             writereg_q,  writereg_d;
  logic [1:0]       memwrite_q,  memwrite_d;
  logic [2:0]       regaddress_q, regaddress_d;

  // Decode the incoming instruction into the next output-register contents
  always_comb begin
    alu1_d       = '0;
    alu2_d       = '0;
    address_d    = '0;
    storedata_d  = '0;
    pcout_d      = bus.pcin;
    opcode_d     = '0;
    writereg_d   = 1'b0;
    memwrite_d   = c_MEM_NONE;
    regaddress_d = '0;
    case (w_cls)
      c_CLS_ALU: begin
        alu1_d       = w_src1;
        alu2_d       = (w_op <= c_OP_LAST_REG) ? w_src2 : w_imm4;
        opcode_d     = w_op;
        writereg_d   = 1'b1;
        memwrite_d   = c_MEM_NONE;
        regaddress_d = w_b;
      end
      c_CLS_LOAD: begin
        alu2_d       = w_src2;
        address_d    = w_src2 + w_sext;
        writereg_d   = 1'b1;
        memwrite_d   = c_MEM_LOAD;
        regaddress_d = w_a;
      end
      c_CLS_STORE: begin
        alu1_d       = w_src1;
        alu2_d       = w_src2;
        storedata_d  = w_src1;
        address_d    = w_src2 + w_sext;
        writereg_d   = 1'b0;
        memwrite_d   = c_MEM_STORE;
      end
      default: begin
        // Absolute load: address is the sign-extended displacement alone
        address_d    = w_sext;
        writereg_d   = 1'b1;
        memwrite_d   = c_MEM_LOAD;
        regaddress_d = w_b;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and load-use hazard
  // --------------------------------------------------------------------------
  logic w_advance;
  logic w_held_load;
  logic w_hazard;
  logic w_instready;
  logic w_accept;

  // The held load's result is not available yet, so a reader must wait a cycle
  assign w_advance   = !outvalid_q || bus.outready;
  assign w_held_load = outvalid_q && (memwrite_q == c_MEM_LOAD);
  assign w_hazard    = w_held_load && bus.invalid &&
                       ((w_use1 && (w_a == regaddress_q)) ||
                        (w_use2 && (w_b == regaddress_q)));
  assign w_instready = resetn && w_advance && !w_hazard && !bus.flush;
  assign w_accept    = bus.invalid && w_instready;

  assign bus.instready = w_instready;

  // Output register: flush kills, advance loads or bubbles, otherwise hold
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      outvalid_q   <= 1'b0;
      alu1_q       <= '0;
      alu2_q       <= '0;
      address_q    <= '0;
      storedata_q  <= '0;
      pcout_q      <= '0;
      opcode_q     <= '0;
      writereg_q   <= 1'b0;
      memwrite_q   <= c_MEM_NONE;
      regaddress_q <= '0;
    end else if (bus.flush) begin
      outvalid_q   <= 1'b0;
    end else if (w_advance) begin
      outvalid_q   <= w_accept;
      if (w_accept) begin
        alu1_q       <= alu1_d;
        alu2_q       <= alu2_d;
        address_q    <= address_d;
        storedata_q  <= storedata_d;
        pcout_q      <= pcout_d;
        opcode_q     <= opcode_d;
        writereg_q   <= writereg_d;
        memwrite_q   <= memwrite_d;
        regaddress_q <= regaddress_d;
      end
    end
  end

  assign bus.outvalid   = outvalid_q;
  assign bus.alu1       = alu1_q;
  assign bus.alu2       = alu2_q;
  assign bus.address    = address_q;
  assign bus.storedata  = storedata_q;
  assign bus.pcout      = pcout_q;
  assign bus.opcode     = opcode_q;
  assign bus.writereg   = writereg_q;
  assign bus.memwrite   = memwrite_q;
  assign bus.regaddress = regaddress_q;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_stage
// ----------------------------------------------------------------------------
// Directed scenarios plus randomized traffic against a behavioural model for
// two decode_stage instances (bypass enabled and disabled) fed identically.
// Revision: 1.0
// ============================================================================
module tb_decode_stage;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] alu1;
    logic [W-1:0] alu2;
    logic [W-1:0] address;
    logic [W-1:0] storedata;
    logic [W-1:0] pcout;
    logic [3:0]   opcode;
    logic         writereg;
    logic [1:0]   memwrite;
    logic [2:0]   regaddress;
  } out_t;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // Shared stimulus
  logic         t_invalid, t_flush, t_outready, t_wbe;
  logic [15:0]  t_instr;
  logic [W-1:0] t_pcin, t_wbd;
  logic [2:0]   t_wba;
  logic [W-1:0] regs [8];

  decode_if #(.WIDTH(W)) bus1 ();
  decode_if #(.WIDTH(W)) bus0 ();

  decode_stage #(.WIDTH(W), .FWD(1)) dut1 (.clock(clock), .resetn(resetn), .bus(bus1));
  decode_stage #(.WIDTH(W), .FWD(0)) dut0 (.clock(clock), .resetn(resetn), .bus(bus0));

  assign bus1.invalid  = t_invalid;  assign bus0.invalid  = t_invalid;
  assign bus1.instr    = t_instr;    assign bus0.instr    = t_instr;
  assign bus1.pcin     = t_pcin;     assign bus0.pcin     = t_pcin;
  assign bus1.wbenable = t_wbe;      assign bus0.wbenable = t_wbe;
  assign bus1.wbaddr   = t_wba;      assign bus0.wbaddr   = t_wba;
  assign bus1.wbdata   = t_wbd;      assign bus0.wbdata   = t_wbd;
  assign bus1.flush    = t_flush;    assign bus0.flush    = t_flush;
  assign bus1.outready = t_outready; assign bus0.outready = t_outready;
  assign bus1.rs1data  = regs[bus1.rs1addr];
  assign bus1.rs2data  = regs[bus1.rs2addr];
  assign bus0.rs1data  = regs[bus0.rs1addr];
  assign bus0.rs2data  = regs[bus0.rs2addr];

  out_t act1, act0;
  assign act1 = {bus1.alu1, bus1.alu2, bus1.address, bus1.storedata, bus1.pcout,
                 bus1.opcode, bus1.writereg, bus1.memwrite, bus1.regaddress};
  assign act0 = {bus0.alu1, bus0.alu2, bus0.address, bus0.storedata, bus0.pcout,
                 bus0.opcode, bus0.writereg, bus0.memwrite, bus0.regaddress};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic out_t mk(input logic [W-1:0] a1, input logic [W-1:0] a2,
                              input logic [W-1:0] ad, input logic [W-1:0] sd,
                              input logic [W-1:0] pc, input logic [3:0] op,
                              input logic wr, input logic [1:0] mw, input logic [2:0] ra);
    out_t r;
    r.alu1 = a1; r.alu2 = a2; r.address = ad; r.storedata = sd; r.pcout = pc;
    r.opcode = op; r.writereg = wr; r.memwrite = mw; r.regaddress = ra;
    return r;
  endfunction

  // Reference decode straight from the instruction-set rules
  function automatic out_t model_decode(input logic [15:0] ins, input logic [W-1:0] pc,
                                        input bit fwd);
    out_t r;
    logic [2:0]   a, b;
    logic [W-1:0] s1, s2, sx;
    a  = ins[13:11];
    b  = ins[10:8];
    s1 = (fwd && t_wbe && t_wba == a) ? t_wbd : regs[a];
    s2 = (fwd && t_wbe && t_wba == b) ? t_wbd : regs[b];
    sx = {{(W-8){ins[7]}}, ins[7:0]};
    r  = '0;
    r.pcout = pc;
    case (ins[15:14])
      2'd3: begin
        r.alu1 = s1;
        r.alu2 = (ins[7:4] <= 4'd8) ? s2 : W'(ins[3:0]);
        r.opcode = ins[7:4]; r.writereg = 1'b1; r.regaddress = b;
      end
      2'd0: begin
        r.alu2 = s2; r.address = s2 + sx;
        r.writereg = 1'b1; r.memwrite = 2'b01; r.regaddress = a;
      end
      2'd1: begin
        r.alu1 = s1; r.alu2 = s2; r.storedata = s1; r.address = s2 + sx;
        r.memwrite = 2'b10;
      end
      default: begin
        r.address = sx; r.writereg = 1'b1; r.memwrite = 2'b01; r.regaddress = b;
      end
    endcase
    return r;
  endfunction

  function automatic bit reads_reg(input logic [15:0] ins, input logic [2:0] r);
    logic [2:0] a, b;
    a = ins[13:11];
    b = ins[10:8];
    case (ins[15:14])
      2'd0:    return b == r;
      2'd1:    return (a == r) || (b == r);
      2'd2:    return 1'b0;
      default: return (a == r) || ((ins[7:4] <= 4'd8) && (b == r));
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    t_invalid = 1'b0; t_flush = 1'b0; t_outready = 1'b1;
    t_wbe = 1'b0; t_wba = 3'd0; t_wbd = '0; t_instr = 16'h0000; t_pcin = '0;
  endtask

  task automatic test_reset();
    out_t zero;
    zero = '0;
    set_idle();
    resetn = 1'b0;
    regs[1] = 16'h0005; regs[0] = 16'h0007;
    t_invalid = 1'b1; t_instr = 16'hC820;
    #2;
    n_tests++;
    if (bus1.instready !== 1'b0) begin n_fail++; $display("FAIL reset_instready: got %b want 0", bus1.instready); end
    tick();
    n_tests++;
    if (bus1.outvalid !== 1'b0 || act1 !== zero) begin
      n_fail++; $display("FAIL reset_outputs: valid %b data %h want 0", bus1.outvalid, act1);
    end
    resetn = 1'b1;
    #2;
    n_tests++;
    if (bus1.instready !== 1'b1) begin n_fail++; $display("FAIL reset_first_ready: got %b want 1", bus1.instready); end
    tick();
    n_tests++;
    if (bus1.outvalid !== 1'b1) begin n_fail++; $display("FAIL reset_first_accept: got %b want 1", bus1.outvalid); end
    set_idle();
    tick();
  endtask

  task automatic test_alu();
    out_t e;
    regs[1] = 16'h0005; regs[0] = 16'h0007;
    t_invalid = 1'b1; t_instr = 16'hC820; t_pcin = 16'h0100;
    #2;
    n_tests++;
    if (bus1.rs1addr !== 3'd1 || bus1.rs2addr !== 3'd0) begin
      n_fail++; $display("FAIL alu_rsaddr: got %0d/%0d want 1/0", bus1.rs1addr, bus1.rs2addr);
    end
    tick();
    e = mk(16'h5, 16'h7, 16'h0, 16'h0, 16'h0100, 4'd2, 1'b1, 2'b00, 3'd0);
    n_tests++;
    if (bus1.outvalid !== 1'b1 || act1 !== e) begin
      n_fail++; $display("FAIL alu_reg: valid %b got %h want %h", bus1.outvalid, act1, e);
    end
    t_instr = 16'hC89A; t_pcin = 16'h0102;
    tick();
    e = mk(16'h5, 16'hA, 16'h0, 16'h0, 16'h0102, 4'd9, 1'b1, 2'b00, 3'd0);
    n_tests++;
    if (act1 !== e) begin n_fail++; $display("FAIL alu_imm: got %h want %h", act1, e); end
    set_idle();
    tick();
    n_tests++;
    if (bus1.outvalid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %b want 0", bus1.outvalid); end
  endtask

  task automatic test_load();
    out_t e;
    regs[2] = 16'h0010;
    t_invalid = 1'b1; t_instr = 16'h0AFE; t_pcin = 16'h0200;
    tick();
    e = mk(16'h0, 16'h0010, 16'h000E, 16'h0, 16'h0200, 4'd0, 1'b1, 2'b01, 3'd1);
    n_tests++;
    if (act1 !== e) begin n_fail++; $display("FAIL load_basic: got %h want %h", act1, e); end
    regs[2] = 16'hFFFF; t_instr = 16'h0A01; t_pcin = 16'h0202;
    tick();
    e = mk(16'h0, 16'hFFFF, 16'h0000, 16'h0, 16'h0202, 4'd0, 1'b1, 2'b01, 3'd1);
    n_tests++;
    if (act1 !== e) begin n_fail++; $display("FAIL load_wrap: got %h want %h", act1, e); end
    t_instr = 16'h8580; t_pcin = 16'h0204;
    tick();
    e = mk(16'h0, 16'h0, 16'hFF80, 16'h0, 16'h0204, 4'd0, 1'b1, 2'b01, 3'd5);
    n_tests++;
    if (act1 !== e) begin n_fail++; $display("FAIL load_abs: got %h want %h", act1, e); end
    set_idle();
    tick();
  endtask

  task automatic test_hazard();
    out_t e;
    regs[1] = 16'h0055; regs[2] = 16'h0010; regs[0] = 16'h0007;
    t_invalid = 1'b1; t_instr = 16'h0AFE; t_pcin = 16'h0300;
    tick();
    t_instr = 16'hC820; t_pcin = 16'h0302;
    #2;
    n_tests++;
    if (bus1.instready !== 1'b0) begin n_fail++; $display("FAIL hazard_stall: got %b want 0", bus1.instready); end
    tick();
    n_tests++;
    if (bus1.outvalid !== 1'b0) begin n_fail++; $display("FAIL hazard_bubble: got %b want 0", bus1.outvalid); end
    #2;
    n_tests++;
    if (bus1.instready !== 1'b1) begin n_fail++; $display("FAIL hazard_release: got %b want 1", bus1.instready); end
    tick();
    e = mk(16'h0055, 16'h0007, 16'h0, 16'h0, 16'h0302, 4'd2, 1'b1, 2'b00, 3'd0);
    n_tests++;
    if (bus1.outvalid !== 1'b1 || act1 !== e) begin
      n_fail++; $display("FAIL hazard_issue: valid %b got %h want %h", bus1.outvalid, act1, e);
    end
    set_idle();
    tick();
  endtask

  task automatic test_backpressure();
    out_t ex, ey;
    regs[1] = 16'h0005; regs[0] = 16'h0007; regs[2] = 16'h0022;
    t_invalid = 1'b1; t_instr = 16'hC820; t_pcin = 16'h0400;
    tick();
    ex = mk(16'h5, 16'h7, 16'h0, 16'h0, 16'h0400, 4'd2, 1'b1, 2'b00, 3'd0);
    t_outready = 1'b0; t_instr = 16'hD1A3; t_pcin = 16'h0404;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_tests++;
      if (bus1.instready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b want 0", i, bus1.instready); end
      tick();
      n_tests++;
      if (bus1.outvalid !== 1'b1 || act1 !== ex) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: valid %b got %h want %h", i, bus1.outvalid, act1, ex);
      end
    end
    t_outready = 1'b1;
    #2;
    n_tests++;
    if (bus1.instready !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b want 1", bus1.instready); end
    tick();
    ey = mk(16'h0022, 16'h0003, 16'h0, 16'h0, 16'h0404, 4'hA, 1'b1, 2'b00, 3'd1);
    n_tests++;
    if (bus1.outvalid !== 1'b1 || act1 !== ey) begin
      n_fail++; $display("FAIL bp_next: valid %b got %h want %h", bus1.outvalid, act1, ey);
    end
    set_idle();
    tick();
  endtask

  task automatic test_forward();
    out_t e1, e0;
    regs[3] = 16'h1234; regs[0] = 16'h0100;
    t_invalid = 1'b1; t_instr = 16'h5804; t_pcin = 16'h0500;
    t_wbe = 1'b1; t_wba = 3'd3; t_wbd = 16'hBEEF;
    tick();
    e1 = mk(16'hBEEF, 16'h0100, 16'h0104, 16'hBEEF, 16'h0500, 4'd0, 1'b0, 2'b10, 3'd0);
    e0 = mk(16'h1234, 16'h0100, 16'h0104, 16'h1234, 16'h0500, 4'd0, 1'b0, 2'b10, 3'd0);
    n_tests++;
    if (act1 !== e1) begin n_fail++; $display("FAIL fwd_on: got %h want %h", act1, e1); end
    n_tests++;
    if (act0 !== e0) begin n_fail++; $display("FAIL fwd_off: got %h want %h", act0, e0); end
    set_idle();
    tick();
  endtask

  task automatic test_flush();
    regs[1] = 16'h0005; regs[0] = 16'h0007; regs[2] = 16'h0010;
    t_invalid = 1'b1; t_instr = 16'hC820; t_pcin = 16'h0600;
    tick();
    t_outready = 1'b0; t_flush = 1'b1; t_instr = 16'h0AFE; t_pcin = 16'h0602;
    #2;
    n_tests++;
    if (bus1.instready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus1.instready); end
    tick();
    n_tests++;
    if (bus1.outvalid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b want 0", bus1.outvalid); end
    t_flush = 1'b0; t_outready = 1'b1;
    tick();
    n_tests++;
    if (bus1.outvalid !== 1'b1 || bus1.address !== 16'h000E || bus1.pcout !== 16'h0602) begin
      n_fail++; $display("FAIL flush_reissue: valid %b addr %h pc %h want 1 000e 0602",
                         bus1.outvalid, bus1.address, bus1.pcout);
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset_stall();
    out_t zero;
    zero = '0;
    regs[2] = 16'h0010;
    t_invalid = 1'b1; t_instr = 16'h0AFE; t_pcin = 16'h0700;
    tick();
    t_instr = 16'hC820; t_outready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (bus1.outvalid !== 1'b0 || act1 !== zero || bus1.instready !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: valid %b ready %b data %h want 0",
                         bus1.outvalid, bus1.instready, act1);
    end
    tick();
    resetn = 1'b1;
    set_idle();
    tick();
  endtask

  task automatic test_random();
    bit   m_valid, adv, haz, rdy;
    out_t m_f1, m_f0;
    set_idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    m_valid = 1'b0; m_f1 = '0; m_f0 = '0;
    for (int c = 0; c < 600; c++) begin
      t_invalid  = ($urandom_range(0, 9) < 7);
      t_instr    = 16'($urandom);
      t_pcin     = W'($urandom);
      t_flush    = ($urandom_range(0, 19) == 0);
      t_outready = ($urandom_range(0, 3) != 0);
      t_wbe      = 1'($urandom_range(0, 1));
      t_wba      = 3'($urandom_range(0, 7));
      t_wbd      = W'($urandom);
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = W'($urandom);
      #2;
      adv = !m_valid || t_outready;
      haz = m_valid && (m_f1.memwrite == 2'b01) && t_invalid && reads_reg(t_instr, m_f1.regaddress);
      rdy = adv && !haz && !t_flush;
      n_tests++;
      if (bus1.instready !== rdy || bus0.instready !== rdy) begin
        n_fail++; $display("FAIL rand_ready cycle %0d: got %b/%b want %b", c, bus1.instready, bus0.instready, rdy);
      end
      n_tests++;
      if (bus1.rs1addr !== t_instr[13:11] || bus1.rs2addr !== t_instr[10:8]) begin
        n_fail++; $display("FAIL rand_rsaddr cycle %0d: got %0d/%0d want %0d/%0d", c,
                           bus1.rs1addr, bus1.rs2addr, t_instr[13:11], t_instr[10:8]);
      end
      if (t_flush) begin
        m_valid = 1'b0;
      end else if (adv) begin
        if (t_invalid && rdy) begin
          m_f1 = model_decode(t_instr, t_pcin, 1'b1);
          m_f0 = model_decode(t_instr, t_pcin, 1'b0);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      tick();
      n_tests++;
      if (bus1.outvalid !== m_valid || bus0.outvalid !== m_valid) begin
        n_fail++; $display("FAIL rand_valid cycle %0d: got %b/%b want %b", c, bus1.outvalid, bus0.outvalid, m_valid);
      end
      if (m_valid) begin
        n_tests++;
        if (act1 !== m_f1 || act0 !== m_f0) begin
          n_fail++; $display("FAIL rand_data cycle %0d: got %h/%h want %h/%h", c, act1, act0, m_f1, m_f0);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    set_idle();
    test_reset();
    test_alu();
    test_load();
    test_hazard();
    test_backpressure();
    test_forward();
    test_flush();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decode_stage
`default_nettype wire
